parking_gate_ctrl: RTL and testbench
====================================

// Module: parking_gate_ctrl
// PURPOSE
//  Sequences the single shared barrier of the car park between an entry lane and an exit lane.
//  Arbitrates the two lane requests and runs the barrier open/wait/close state machine.
//  Keeps the registered occupancy count and drives the one-digit 7-segment occupancy display.
//  Sits between the lane sensors/barrier motor and the display; the only owner of the count.
// PARAMETERS
//  CAPACITY        8   number of bays; occupancy saturates at this value (1..15)
//  CNT_W           4   occupancy width; must hold CAPACITY
//  TRAVEL_CYCLES   4   cycles the barrier takes to open, and again to close (>=1)
//  TIMEOUT_CYCLES  16  max cycles in WAIT_PASS before closing with no car (>=1)
// PORTS
//  clk        in   1      system clock, rising edge
//  rst_n      in   1      synchronous reset, active low
//  entry_req  in   1      level: car waiting at the entry loop
//  exit_req   in   1      level: car waiting at the exit loop
//  car_passed in   1      one-cycle pulse: car has cleared the barrier beam
//  gate_cmd   out  1      barrier motor command, 1 = raise/hold up
//  entry_gnt  out  1      entry lane owns the barrier
//  exit_gnt   out  1      exit lane owns the barrier
//  occupancy  out  CNT_W  registered count of parked cars
//  full       out  1      occupancy == CAPACITY
//  empty      out  1      occupancy == 0
//  seg        out  7      active-low segments {g,f,e,d,c,b,a} showing occupancy
//  AN         out  4      digit enables, active low; constant 4'b1110
// BEHAVIOUR
//  Reset (rst_n low at a clk edge, any state): state IDLE, occupancy 0, gate_cmd/entry_gnt/exit_gnt 0,
//   timers 0, last_served = ENTRY; full 0, empty 1, seg 7'b1000000. A cycle in progress is abandoned.
//  Eligibility: entry eligible = entry_req & ~full; exit eligible = exit_req & ~empty.
//  Arbitration (IDLE only): one eligible -> grant it; both -> grant lane opposite last_served
//   (first contention after reset goes to EXIT); none -> stay IDLE. last_served updated at grant.
//  FSM (all transitions registered):
//   IDLE      -> OPENING on grant; grant flag and gate_cmd rise the cycle after the request is seen.
//   OPENING   gate_cmd 1; stays exactly TRAVEL_CYCLES cycles -> WAIT_PASS.
//   WAIT_PASS gate_cmd 1; car_passed -> CLOSING and count update; TIMEOUT_CYCLES with no pulse
//             -> CLOSING, no count change.
//   CLOSING   gate_cmd 0; stays exactly TRAVEL_CYCLES cycles -> IDLE; grant drops on leaving.
//  Grant held constant from OPENING entry to CLOSING exit; exactly one grant high outside IDLE.
//  Requests dropping mid-cycle do not abort; cycle completes (timeout path if no car).
//  Count: on car_passed in WAIT_PASS, entry +1, exit -1, visible on occupancy the next cycle.
//   Saturates at CAPACITY and 0 (cannot occur given eligibility; guard anyway).
//  car_passed outside WAIT_PASS is ignored. Back-to-back: earliest re-grant is 1 cycle after IDLE entry.
//  full/empty/seg are combinational from the occupancy register.
//  seg table: 0..9 standard active-low digits (0=1000000,1=1111001,...,8=0000000,9=0010000);
//   values >9 show '-' = 7'b0111111.
// TESTING
//  1 Reset: hold rst_n=0 3 cycles with entry_req=1 -> all outputs at reset values, seg=1000000, AN=1110.
//  2 Single entry: entry_req=1 at IDLE -> entry_gnt/gate_cmd 1 next cycle, WAIT_PASS after 4 cycles,
//    car_passed pulse -> occupancy 1, seg=1111001, gate_cmd 0 for 4 cycles, back to IDLE.
//  3 Fill to CAPACITY=8 with 8 entry cycles -> full=1, seg=0000000; 9th entry_req gets no grant.
//  4 Contention: occupancy 3, entry_req=exit_req=1 -> exit_gnt first (occupancy 2), then entry_gnt
//    (occupancy 3), then exit again: strict alternation.
//  5 Timeout: entry granted, no car_passed -> CLOSING after 16 WAIT_PASS cycles, occupancy unchanged;
//    car_passed pulses in IDLE/OPENING/CLOSING -> no count change.
//  6 Empty guard + mid-op reset: exit_req at occupancy 0 -> no grant; reset in WAIT_PASS -> IDLE, occupancy 0.

Source files
------------

// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl
//   Owns the single car-park barrier shared by an entry and an exit lane.
//   It arbitrates the two lanes, runs the barrier open/wait/close sequence,
//   keeps the occupancy count and drives a one-digit 7-segment display.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       synchronous reset, active low
//   entry_req   level, car waiting at the entry loop
//   exit_req    level, car waiting at the exit loop
//   car_passed  one-cycle pulse, car has cleared the barrier beam
//   gate_cmd    barrier motor command, 1 = raise/hold up
//   entry_gnt   entry lane owns the barrier
//   exit_gnt    exit lane owns the barrier
//   occupancy   registered count of parked cars
//   full        occupancy == CAPACITY
//   empty       occupancy == 0
//   seg         active-low segments {g,f,e,d,c,b,a} showing occupancy
//   AN          active-low digit enables, only digit 0 is used
//
// state     | meaning
// IDLE      | barrier down, arbitrating lane requests
// OPENING   | barrier rising for TRAVEL_CYCLES cycles
// WAIT_PASS | barrier up, waiting for car_passed or timeout
// CLOSING   | barrier lowering for TRAVEL_CYCLES cycles
module parking_gate_ctrl #(
  parameter int CAPACITY       = 8,
  parameter int CNT_W          = 4,
  parameter int TRAVEL_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             entry_req,
  input  logic             exit_req,
  input  logic             car_passed,
  output logic             gate_cmd,
  output logic             entry_gnt,
  output logic             exit_gnt,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic [6:0]       seg,
  output logic [3:0]       AN
);

  localparam int TMR_MAX = (TIMEOUT_CYCLES > TRAVEL_CYCLES) ? TIMEOUT_CYCLES : TRAVEL_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [1:0] {IDLE, OPENING, WAIT_PASS, CLOSING} state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             lane_exit_q, lane_exit_d;   // lane owning the current cycle
  logic             last_exit_q, last_exit_d;   // last_served: 0 = ENTRY, 1 = EXIT
  logic             gate_cmd_q, gate_cmd_d;
  logic             entry_gnt_q, entry_gnt_d;
  logic             exit_gnt_q, exit_gnt_d;
  logic             entry_elig, exit_elig;

  assign full  = (occ_q == CNT_W'(CAPACITY));
  assign empty = (occ_q == '0);
  assign entry_elig = entry_req & ~full;
  assign exit_elig  = exit_req & ~empty;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    occ_d       = occ_q;
    lane_exit_d = lane_exit_q;
    last_exit_d = last_exit_q;

    case (state_q)
      IDLE: begin
        if (entry_elig || exit_elig) begin
          // Under contention the lane not served last time wins.
          lane_exit_d = exit_elig & (~entry_elig | ~last_exit_q);
          last_exit_d = lane_exit_d;
          state_d     = OPENING;
          timer_d     = TMR_W'(TRAVEL_CYCLES - 1);
        end
      end
      OPENING: begin
        if (timer_q == '0) begin
          state_d = WAIT_PASS;
          timer_d = TMR_W'(TIMEOUT_CYCLES - 1);
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      WAIT_PASS: begin
        if (car_passed) begin
          if (lane_exit_q) begin
            if (occ_q != '0) occ_d = occ_q - CNT_W'(1);
          end else begin
            if (occ_q != CNT_W'(CAPACITY)) occ_d = occ_q + CNT_W'(1);
          end
          state_d = CLOSING;
          timer_d = TMR_W'(TRAVEL_CYCLES - 1);
        end else if (timer_q == '0) begin
          state_d = CLOSING;
          timer_d = TMR_W'(TRAVEL_CYCLES - 1);
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      CLOSING: begin
        if (timer_q == '0) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

    // Outputs are registered images of the next state.
    gate_cmd_d  = (state_d == OPENING) || (state_d == WAIT_PASS);
    entry_gnt_d = (state_d != IDLE) && !lane_exit_d;
    exit_gnt_d  = (state_d != IDLE) && lane_exit_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      occ_q       <= '0;
      lane_exit_q <= 1'b0;
      last_exit_q <= 1'b0;
      gate_cmd_q  <= 1'b0;
      entry_gnt_q <= 1'b0;
      exit_gnt_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      occ_q       <= occ_d;
      lane_exit_q <= lane_exit_d;
      last_exit_q <= last_exit_d;
      gate_cmd_q  <= gate_cmd_d;
      entry_gnt_q <= entry_gnt_d;
      exit_gnt_q  <= exit_gnt_d;
    end
  end

  always_comb begin
    seg = 7'b0111111;
    case (int'(occ_q))
      0: seg = 7'b1000000;
      1: seg = 7'b1111001;
      2: seg = 7'b0100100;
      3: seg = 7'b0110000;
      4: seg = 7'b0011001;
      5: seg = 7'b0010010;
      6: seg = 7'b0000010;
      7: seg = 7'b1111000;
      8: seg = 7'b0000000;
      9: seg = 7'b0010000;
      default: seg = 7'b0111111;
    endcase
  end

  assign gate_cmd  = gate_cmd_q;
  assign entry_gnt = entry_gnt_q;
  assign exit_gnt  = exit_gnt_q;
  assign occupancy = occ_q;
  assign AN        = 4'b1110;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// tb_parking_gate_ctrl
//   Self-checking bench for parking_gate_ctrl. A timestamp-based model of the
//   barrier cycle (grant time, close time) predicts every output each cycle.
module tb_parking_gate_ctrl;

  localparam int CAP = 8;
  localparam int T   = 4;
  localparam int TO  = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       entry_req = 1'b0;
  logic       exit_req = 1'b0;
  logic       car_passed = 1'b0;
  logic       gate_cmd, entry_gnt, exit_gnt, full, empty;
  logic [3:0] occupancy;
  logic [6:0] seg;
  logic [3:0] AN;

  parking_gate_ctrl #(.CAPACITY(CAP), .CNT_W(4), .TRAVEL_CYCLES(T), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .entry_req(entry_req), .exit_req(exit_req),
    .car_passed(car_passed), .gate_cmd(gate_cmd), .entry_gnt(entry_gnt),
    .exit_gnt(exit_gnt), .occupancy(occupancy), .full(full), .empty(empty),
    .seg(seg), .AN(AN)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: a cycle is described by its grant edge and (once known) its close edge.
  int cyc = 0;
  bit m_busy = 0;
  bit m_lane_exit = 0;
  bit m_last_exit = 0;
  int m_g = 0;
  int m_close = -1;
  int m_occ = 0;

  logic [6:0] seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit e, input bit x, input bit p);
    bit ee, xe;
    cyc++;
    if (!r) begin
      m_busy = 0; m_lane_exit = 0; m_last_exit = 0; m_close = -1; m_occ = 0;
    end else if (m_busy && m_close >= 0) begin
      if (cyc == m_close + T) begin
        m_busy = 0;
        m_close = -1;
      end
    end else if (m_busy) begin
      if (cyc - 1 - m_g >= T) begin
        if (p) begin
          if (m_lane_exit) m_occ = (m_occ > 0) ? m_occ - 1 : 0;
          else             m_occ = (m_occ < CAP) ? m_occ + 1 : CAP;
          m_close = cyc;
        end else if (cyc == m_g + T + TO) begin
          m_close = cyc;
        end
      end
    end else begin
      ee = e && (m_occ < CAP);
      xe = x && (m_occ > 0);
      if (ee || xe) begin
        m_lane_exit = (ee && xe) ? !m_last_exit : xe;
        m_last_exit = m_lane_exit;
        m_busy = 1;
        m_g = cyc;
        m_close = -1;
      end
    end
  endtask

  task automatic check_outputs();
    logic [6:0] exp_seg;
    exp_seg = (m_occ <= 9) ? seg_tbl[m_occ] : 7'b0111111;
    chk("gate_cmd",  {7'b0, gate_cmd},  {7'b0, m_busy && m_close < 0});
    chk("entry_gnt", {7'b0, entry_gnt}, {7'b0, m_busy && !m_lane_exit});
    chk("exit_gnt",  {7'b0, exit_gnt},  {7'b0, m_busy && m_lane_exit});
    chk("occupancy", {4'b0, occupancy}, 8'(m_occ));
    chk("full",      {7'b0, full},      {7'b0, m_occ == CAP});
    chk("empty",     {7'b0, empty},     {7'b0, m_occ == 0});
    chk("seg",       {1'b0, seg},       {1'b0, exp_seg});
    chk("AN",        {4'b0, AN},        8'h0E);
  endtask

  task automatic step(input bit r, input bit e, input bit x, input bit p);
    rst_n = r; entry_req = e; exit_req = x; car_passed = p;
    @(posedge clk);
    model_edge(r, e, x, p);
    #1;
    check_outputs();
  endtask

  task automatic bound_fail(input string tag);
    checks++;
    errors++;
    $error("FAIL %s cyc=%0d observed=bound expired expected=event", tag, cyc);
  endtask

  // Advance until the model says the barrier is up and waiting for the car.
  task automatic run_to_wait();
    int n = 0;
    while (!(m_busy && m_close < 0 && cyc - m_g >= T) && n < 50) begin
      step(1, 0, 0, 0);
      n++;
    end
    if (n >= 50) bound_fail("wait_bound");
  endtask

  task automatic run_to_idle();
    int n = 0;
    while (m_busy && n < 100) begin
      step(1, 0, 0, 0);
      n++;
    end
    if (n >= 100) bound_fail("idle_bound");
  endtask

  task automatic serve(input bit e, input bit x, input bit pass, input bit exp_exit);
    step(1, e, x, 0);
    chk("serve_exit_gnt",  {7'b0, exit_gnt},  {7'b0, exp_exit});
    chk("serve_entry_gnt", {7'b0, entry_gnt}, {7'b0, !exp_exit});
    chk("serve_gate",      {7'b0, gate_cmd},  8'h01);
    run_to_wait();
    if (pass) step(1, 0, 0, 1);
    run_to_idle();
  endtask

  initial begin
    int gate_cnt;
    int occ_saved;

    // 1: reset with entry_req held high
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    chk("rst_seg", {1'b0, seg}, 8'h40);
    chk("rst_an", {4'b0, AN}, 8'h0E);
    chk("rst_empty", {7'b0, empty}, 8'h01);
    chk("rst_entry_gnt", {7'b0, entry_gnt}, 8'h00);

    // 2: single entry
    serve(1, 0, 1, 0);
    chk("single_occ", {4'b0, occupancy}, 8'h01);
    chk("single_seg", {1'b0, seg}, 8'h79);
    serve(1, 0, 1, 0);
    serve(1, 0, 1, 0);

    // 4: contention from occupancy 3 alternates starting with exit
    serve(1, 1, 1, 1);
    chk("cont_occ_a", {4'b0, occupancy}, 8'h02);
    serve(1, 1, 1, 0);
    chk("cont_occ_b", {4'b0, occupancy}, 8'h03);
    serve(1, 1, 1, 1);
    chk("cont_occ_c", {4'b0, occupancy}, 8'h02);

    // 5: timeout plus stray car_passed pulses outside WAIT_PASS
    occ_saved = 2;
    gate_cnt = 0;
    step(1, 1, 0, 0);
    if (gate_cmd) gate_cnt++;
    step(1, 0, 0, 1);
    if (gate_cmd) gate_cnt++;
    for (int i = 0; i < 60 && m_busy && m_close < 0; i++) begin
      step(1, 0, 0, 0);
      if (gate_cmd) gate_cnt++;
    end
    chk("timeout_gate_cycles", 8'(gate_cnt), 8'(T + TO));
    step(1, 0, 0, 1);
    run_to_idle();
    step(1, 0, 0, 1);
    chk("timeout_occ", {4'b0, occupancy}, 8'(occ_saved));

    // 3: fill to capacity, then a further entry request is refused
    for (int i = 0; i < 6; i++) serve(1, 0, 1, 0);
    chk("fill_full", {7'b0, full}, 8'h01);
    chk("fill_seg", {1'b0, seg}, 8'h00);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 0, 0);
      chk("full_no_gnt", {7'b0, entry_gnt}, 8'h00);
    end

    // 6: reset while waiting for a car, then exit refused at empty
    step(1, 0, 1, 0);
    run_to_wait();
    step(0, 0, 0, 0);
    chk("midrst_occ", {4'b0, occupancy}, 8'h00);
    chk("midrst_gate", {7'b0, gate_cmd}, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 1, 0);
      chk("empty_no_gnt", {7'b0, exit_gnt}, 8'h00);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 600) != 0, ($urandom % 3) != 0, ($urandom % 3) == 0, ($urandom % 6) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
